lane_pack_fifo: RTL and testbench
=================================

# lane_pack_fifo

Parametrised lane packer with word buffering. Narrow `LANE_W`-bit beats are assembled into a packed word organised as `[LANES-1:0][LANE_W-1:0]`. Completed words are stored in an unpacked array of `DEPTH` entries and presented on a valid/ready output as first-word-fall-through. The block sits between narrow producers and wide consumers; it supports configurable lane fill order and partial-word flush with a lane-valid mask.

## Interface
- `LANE_W`, default 4: bits per lane; must be ≥1.
- `LANES`, default 3: lanes per packed word; must be ≥1.
- `DEPTH`, default 4: stored words; must be ≥2; need not be a power of 2.
- `MSB_FIRST`, default 1: 1 = first beat goes to lane `LANES-1`; 0 = first beat goes to lane 0.
- Elaboration fails if any parameter is out of range.

Ports (one clock; reset is asynchronous, active-low):
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_data`  in  `LANE_W`  beat payload.
- `in_last`  in  1  closes the current word after this beat, even if partial.
- `out_valid`  out  1  head word present.
- `out_ready`  in  1  head word popped when `out_valid && out_ready`.
- `out_data`  out  `LANES*LANE_W`  head word, packed `[LANES-1:0][LANE_W-1:0]`.
- `out_mask`  out  `LANES`  bit k set = lane k holds a written beat.
- `count`  out  `$clog2(DEPTH+1)`  number of stored words.

## Operation
- Assembly state:
  - packed register `asm_q`, cleared to 0 on reset;
  - beat counter `beat_q`, range 0..LANES-1;
  - mask register `amask_q`.
- Lane for beat n: `LANES-1-n` when `MSB_FIRST`=1, else `n`.
- On accept:
  - `in_data` is written into the selected lane;
  - the corresponding mask bit is set.
- Commit occurs when the accepted beat has n = LANES-1, or when `in_last`=1:
  - the merged word (including the current beat) and its mask are written to `mem[wptr]`;
  - `wptr` advances;
  - `asm_q`, `amask_q` and `beat_q` clear.
- Lanes never written in a committed word read as 0.
- `in_ready` = (`count` != DEPTH). It does not depend combinationally on `out_ready`.
- Pop: `rptr` advances.
- Pointer wrap: each pointer returns to 0 after reaching DEPTH-1.
- `count` update per cycle:
  - +1 on commit only;
  - −1 on pop only;
  - unchanged when both or neither occur.
- `out_valid` = (`count` != 0).
- `out_data`/`out_mask` = `mem[rptr]` (combinational read of the storage array).
- With LANES=1, every beat commits and `in_last` has no effect.
- No overflow or underflow is possible: push is gated by `in_ready`, pop by `out_valid`. A pop when `out_valid`=0 is ignored.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_mask`=0, `count`=0;
  - `in_ready`=1, including while `rst_n` is held low;
  - pointers, `beat_q`, `asm_q` and `amask_q` all 0.
- Reset mid-word: the partial word is discarded. The first beat accepted after reset is beat 0 of a new word.
- Latency: a committing beat is accepted at edge t; `out_valid`/`out_data` reflect it in the cycle after edge t, i.e. 1 cycle.
- Full (`count`=DEPTH): `in_ready`=0. After a pop at edge t, `in_ready`=1 in the cycle following edge t.
- Simultaneous commit and pop with 0<`count`<DEPTH: both occur, and `count` is unchanged.
- Commit when `count`=0: the word is visible on the output the next cycle. There is no same-cycle bypass.
- Storage is written only on commit, never on non-committing beats.

## Structure
- Package `lane_pack_pkg` holds:
  - the `lane_sel(beat, lanes, msb_first)` function;
  - the fill-order enum `FILL_LSB`/`FILL_MSB`, mapped from `MSB_FIRST`.
- Word types are declared in the module from parameters:
  - `typedef logic [LANES-1:0][LANE_W-1:0] word_t`;
  - storage is the unpacked array `word_t mem [DEPTH]`, with a parallel mask array.
- One sub-module, `lane_word_fifo`, contains the storage arrays, `wptr`/`rptr` wrap logic and `count`. The top level holds the assembly logic and the handshakes.

## Test plan
All scenarios use LANE_W=4, LANES=3, DEPTH=4 unless stated.
- MSB_FIRST=1, beats 2,4,6 → `out_data`=12'h246, `out_mask`=3'b111, lane2=2, lane0=6.
- MSB_FIRST=0, beats 2,4,6 → `out_data`=12'h642, `out_mask`=3'b111.
- MSB_FIRST=1, beats 5,1 with `in_last` on beat 1 → `out_data`=12'h510, `out_mask`=3'b110. A following beat 3 starts at lane 2.
- `out_ready`=0 while 12 beats are pushed → `count`=4 and `in_ready`=0. Raising `out_ready` then drains the words in push order, and `in_ready`=1 in the cycle after the first pop.
- At `count`=2, a committing beat and a pop on the same edge → `count` stays 2 and the data order is preserved.
- Assert `rst_n`=0 after 2 beats → all outputs at reset values. The next beats 7,8,9 yield 12'h789 with `out_mask`=3'b111.

Source files
------------

// File: rtl/lane_pack_fifo_pkg.sv
// Shared definitions for the lane packer: fill-order enum and the beat-to-lane mapping.
package lane_pack_pkg;

   typedef enum logic {
      FILL_LSB = 1'b0,
      FILL_MSB = 1'b1
   } fill_e;

   function automatic int lane_sel(input int beat, input int lanes, input bit msb_first);
      return msb_first ? (lanes - 1 - beat) : beat;
   endfunction

endpackage

// File: rtl/lane_pack_fifo_if.sv
// Beat input and packed-word output handshakes of the lane packer, with word count.
interface lane_pack_fifo_if #(
   parameter int LANE_W = 4,
   parameter int LANES  = 3,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                     in_valid;
   logic                     in_ready;
   logic [LANE_W-1:0]        in_data;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*LANE_W-1:0]  out_data;
   logic [LANES-1:0]         out_mask;
   logic [CW-1:0]            count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_mask, count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_mask, count
   );
endinterface

// File: rtl/lane_pack_fifo_word_fifo.sv
// Word storage for the lane packer: data/mask arrays, wrapping pointers and occupancy count.
module lane_word_fifo
   import lane_pack_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int LANES  = 3,
   parameter int DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  logic [LANES-1:0][LANE_W-1:0]  push_data_i,
   input  logic [LANES-1:0]              push_mask_i,
   input  logic                          pop_i,
   output logic [LANES-1:0][LANE_W-1:0]  rd_data_o,
   output logic [LANES-1:0]              rd_mask_o,
   output logic [$clog2(DEPTH+1)-1:0]    count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   typedef logic [LANES-1:0][LANE_W-1:0] word_t;

   word_t            mem      [DEPTH];
   logic [LANES-1:0] mask_mem [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop;

   // A pop request against an empty store is simply dropped.
   assign pop = pop_i && (count_q != '0);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      if (pop)    rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      case ({push_i, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i]      <= '0;
            mask_mem[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (push_i) begin
            mem[wptr_q]      <= push_data_i;
            mask_mem[wptr_q] <= push_mask_i;
         end
      end
   end

   assign rd_data_o = mem[rptr_q];
   assign rd_mask_o = mask_mem[rptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/lane_pack_fifo.sv
// Packs narrow beats into LANES-wide words (configurable fill order, early close on in_last)
// and queues completed words in a first-word-fall-through store.
module lane_pack_fifo
   import lane_pack_pkg::*;
#(
   parameter int LANE_W    = 4,
   parameter int LANES     = 3,
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   lane_pack_fifo_if.slave bus
);
   generate
      if (LANE_W < 1) begin : g_bad_lane_w
         $error("lane_pack_fifo: LANE_W must be >= 1");
      end
      if (LANES < 1) begin : g_bad_lanes
         $error("lane_pack_fifo: LANES must be >= 1");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("lane_pack_fifo: DEPTH must be >= 2");
      end
   endgenerate

   localparam fill_e FILL = MSB_FIRST ? FILL_MSB : FILL_LSB;
   localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(LANES - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

   typedef logic [LANES-1:0][LANE_W-1:0] word_t;

   word_t            asm_q, asm_d, merged, rd_word;
   logic [LANES-1:0] amask_q, amask_d, lane_hit, merged_mask, rd_mask;
   logic [BW-1:0]    beat_q, beat_d;
   logic [CW-1:0]    count;
   logic             accept, commit;

   // One-hot lane select for the current beat, and the word as it would look with this beat merged in.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_hit[gi] = (lane_sel(int'(beat_q), LANES, FILL == FILL_MSB) == gi);
      assign merged[gi]   = lane_hit[gi] ? bus.in_data : asm_q[gi];
   end

   assign merged_mask = amask_q | lane_hit;
   assign accept      = bus.in_valid && bus.in_ready;
   assign commit      = accept && ((beat_q == LAST_BEAT) || bus.in_last);

   always_comb begin
      asm_d   = asm_q;
      amask_d = amask_q;
      beat_d  = beat_q;
      if (accept) begin
         if (commit) begin
            asm_d   = '0;
            amask_d = '0;
            beat_d  = '0;
         end else begin
            asm_d   = merged;
            amask_d = merged_mask;
            beat_d  = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q   <= '0;
         amask_q <= '0;
         beat_q  <= '0;
      end else begin
         asm_q   <= asm_d;
         amask_q <= amask_d;
         beat_q  <= beat_d;
      end
   end

   lane_word_fifo #(
      .LANE_W (LANE_W),
      .LANES  (LANES),
      .DEPTH  (DEPTH)
   ) u_word_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (commit),
      .push_data_i (merged),
      .push_mask_i (merged_mask),
      .pop_i       (bus.out_ready),
      .rd_data_o   (rd_word),
      .rd_mask_o   (rd_mask),
      .count_o     (count)
   );

   // Ready comes only from the registered count, so it holds during reset and never sees out_ready.
   assign bus.in_ready  = (count != FULL_CNT);
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = rd_word;
   assign bus.out_mask  = rd_mask;
   assign bus.count     = count;

endmodule

// File: tb/tb_lane_pack_fifo.sv
// Bench for lane_pack_fifo: MSB-first and LSB-first instances driven in lockstep against a queue model.
module tb_lane_pack_fifo;
   localparam int LW = 4;
   localparam int LN = 3;
   localparam int DP = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lane_pack_fifo_if #(.LANE_W(LW), .LANES(LN), .DEPTH(DP)) bus_m ();
   lane_pack_fifo_if #(.LANE_W(LW), .LANES(LN), .DEPTH(DP)) bus_l ();

   lane_pack_fifo #(.LANE_W(LW), .LANES(LN), .DEPTH(DP), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .bus(bus_m));
   lane_pack_fifo #(.LANE_W(LW), .LANES(LN), .DEPTH(DP), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .bus(bus_l));

   int checks = 0;
   int errors = 0;

   // Reference model: pending beats of the open word, and committed words for each fill order.
   int         beats [$];
   logic [11:0] q_dm [$];
   logic [11:0] q_dl [$];
   logic [2:0]  q_mm [$];
   logic [2:0]  q_ml [$];

   bit         cur_v, cur_l, cur_or;
   logic [3:0] cur_d;

   typedef struct {
      bit          v;
      logic [3:0]  d;
      bit          l;
      bit          ordy;
      bit          e_ov;
      logic [11:0] e_dm;
      logic [11:0] e_dl;
      logic [2:0]  e_mm;
      logic [2:0]  e_ml;
      int          e_cnt;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [3:0] d, input bit l, input bit ordy);
      cur_v = v; cur_d = d; cur_l = l; cur_or = ordy;
      bus_m.in_valid = v; bus_m.in_data = d; bus_m.in_last = l; bus_m.out_ready = ordy;
      bus_l.in_valid = v; bus_l.in_data = d; bus_l.in_last = l; bus_l.out_ready = ordy;
   endtask

   task automatic model_reset();
      beats.delete(); q_dm.delete(); q_dl.delete(); q_mm.delete(); q_ml.delete();
   endtask

   task automatic model_edge();
      int  pre;
      bit  acc, pop;
      logic [11:0] wm, wl;
      logic [2:0]  mm, ml;
      pre = q_dm.size();
      acc = cur_v && (pre != DP);
      pop = cur_or && (pre != 0);
      if (pop) begin
         $display("pop  msb=%03h/%b lsb=%03h/%b", q_dm[0], q_mm[0], q_dl[0], q_ml[0]);
         void'(q_dm.pop_front()); void'(q_dl.pop_front());
         void'(q_mm.pop_front()); void'(q_ml.pop_front());
      end
      if (acc) begin
         beats.push_back(int'(cur_d));
         if (beats.size() == LN || cur_l) begin
            wm = '0; wl = '0; mm = '0; ml = '0;
            for (int i = 0; i < beats.size(); i++) begin
               wm = wm | (12'(beats[i]) << (4 * (LN - 1 - i)));
               mm = mm | (3'b001 << (LN - 1 - i));
               wl = wl | (12'(beats[i]) << (4 * i));
               ml = ml | (3'b001 << i);
            end
            q_dm.push_back(wm); q_dl.push_back(wl);
            q_mm.push_back(mm); q_ml.push_back(ml);
            beats.delete();
         end
      end
   endtask

   task automatic check_model();
      int n;
      n = q_dm.size();
      chk("m_in_ready",  32'(bus_m.in_ready),  32'(n != DP));
      chk("l_in_ready",  32'(bus_l.in_ready),  32'(n != DP));
      chk("m_out_valid", 32'(bus_m.out_valid), 32'(n != 0));
      chk("l_out_valid", 32'(bus_l.out_valid), 32'(n != 0));
      chk("m_count",     32'(bus_m.count),     32'(n));
      chk("l_count",     32'(bus_l.count),     32'(n));
      if (n != 0) begin
         chk("m_out_data", 32'(bus_m.out_data), 32'(q_dm[0]));
         chk("l_out_data", 32'(bus_l.out_data), 32'(q_dl[0]));
         chk("m_out_mask", 32'(bus_m.out_mask), 32'(q_mm[0]));
         chk("l_out_mask", 32'(bus_l.out_mask), 32'(q_ml[0]));
      end
   endtask

   task automatic step(input bit v, input logic [3:0] d, input bit l, input bit ordy);
      drive(v, d, l, ordy);
      @(posedge clk);
      model_edge();
      #2;
      check_model();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_m_in_ready"},  32'(bus_m.in_ready),  32'd1);
      chk({tag, "_l_in_ready"},  32'(bus_l.in_ready),  32'd1);
      chk({tag, "_m_out_valid"}, 32'(bus_m.out_valid), 32'd0);
      chk({tag, "_m_out_data"},  32'(bus_m.out_data),  32'd0);
      chk({tag, "_l_out_data"},  32'(bus_l.out_data),  32'd0);
      chk({tag, "_m_out_mask"},  32'(bus_m.out_mask),  32'd0);
      chk({tag, "_m_count"},     32'(bus_m.count),     32'd0);
      chk({tag, "_l_count"},     32'(bus_l.count),     32'd0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 3'b000, 3'b000, 0};
      tbl[1] = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 3'b000, 3'b000, 0};
      tbl[2] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 12'h246, 12'h642, 3'b111, 3'b111, 1};
      tbl[3] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 3'b000, 3'b000, 0};
      tbl[4] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 3'b000, 3'b000, 0};
      tbl[5] = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 12'h510, 12'h015, 3'b110, 3'b011, 1};
      tbl[6] = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 12'h300, 12'h003, 3'b100, 3'b001, 1};
      tbl[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 3'b000, 3'b000, 0};

      drive(1'b0, 4'h0, 1'b0, 1'b0);
      model_reset();
      #1;
      check_reset_values("rst_held");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      check_reset_values("rst_done");

      // Directed vectors: fill orders, partial flush, restart at first lane.
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
         chk($sformatf("tbl%0d_m_count", i), 32'(bus_m.count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_l_count", i), 32'(bus_l.count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_out_valid", i), 32'(bus_m.out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_in_ready", i), 32'(bus_m.in_ready), 32'd1);
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d_m_data", i), 32'(bus_m.out_data), 32'(tbl[i].e_dm));
            chk($sformatf("tbl%0d_l_data", i), 32'(bus_l.out_data), 32'(tbl[i].e_dl));
            chk($sformatf("tbl%0d_m_mask", i), 32'(bus_m.out_mask), 32'(tbl[i].e_mm));
            chk($sformatf("tbl%0d_l_mask", i), 32'(bus_l.out_mask), 32'(tbl[i].e_ml));
         end
      end

      // Fill to DEPTH with the consumer stalled, try one more beat, then drain.
      for (int i = 0; i < 12; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
      chk("full_count", 32'(bus_m.count), 32'd4);
      chk("full_in_ready", 32'(bus_m.in_ready), 32'd0);
      chk("full_head", 32'(bus_m.out_data), 32'h012);
      step(1'b1, 4'hF, 1'b0, 1'b0);
      chk("full_blocked_count", 32'(bus_m.count), 32'd4);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      chk("after_pop_in_ready", 32'(bus_m.in_ready), 32'd1);
      chk("after_pop_head", 32'(bus_m.out_data), 32'h345);
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b1);
      chk("drained_count", 32'(bus_m.count), 32'd0);

      // Commit and pop on the same edge with two words stored.
      for (int i = 1; i <= 6; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
      chk("two_words_count", 32'(bus_m.count), 32'd2);
      step(1'b1, 4'hA, 1'b0, 1'b0);
      step(1'b1, 4'hB, 1'b0, 1'b0);
      step(1'b1, 4'hC, 1'b0, 1'b1);
      chk("simul_count", 32'(bus_m.count), 32'd2);
      chk("simul_head", 32'(bus_m.out_data), 32'h456);
      for (int i = 0; i < 2; i++) step(1'b0, 4'h0, 1'b0, 1'b1);

      // Reset in the middle of a word discards the partial word.
      step(1'b1, 4'h1, 1'b0, 1'b0);
      step(1'b1, 4'h2, 1'b0, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_values("midrst");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(1'b1, 4'h7, 1'b0, 1'b0);
      step(1'b1, 4'h8, 1'b0, 1'b0);
      step(1'b1, 4'h9, 1'b0, 1'b0);
      chk("post_rst_m_data", 32'(bus_m.out_data), 32'h789);
      chk("post_rst_l_data", 32'(bus_l.out_data), 32'h987);
      chk("post_rst_m_mask", 32'(bus_m.out_mask), 32'b111);
      step(1'b0, 4'h0, 1'b0, 1'b1);

      // Random traffic, alternating phases that favour filling and draining.
      for (int i = 0; i < 400; i++) begin
         bit drain_phase;
         drain_phase = ((i / 50) % 2) == 1;
         step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 4) == 0,
              drain_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
